writeback_queue: RTL and testbench
==================================

Name: writeback_queue

Overview:
Writeback stage directly upstream of the register file. Accepts ALU results and memory-load results, buffers them in a small in-order queue, and drains one entry per cycle onto the register-file write port (write_enable, dest, mem_data_in select, data). It also exposes a pending-write lookup so the operand stage can detect read-after-write hazards and forward the youngest queued value.

Parameters:
DEPTH, 4, queue entries; power of two, minimum 2.
DATA_W, 32, result width.
REG_AW, 4, register address width.

Ports:
clk  in  1  rising-edge clock.
rst  in  1  synchronous, active-high reset.
alu_valid  in  1  ALU result offered.
alu_dest  in  REG_AW  ALU destination register.
alu_result  in  DATA_W  ALU result.
alu_ready  out  1  ALU result accepted this cycle.
mem_valid  in  1  load result offered.
mem_dest  in  REG_AW  load destination register.
mem_data  in  DATA_W  load data.
mem_ready  out  1  load result accepted this cycle.
wr_hold  in  1  suppresses the drain this cycle.
wr_en  out  1  register-file write_enable.
wr_dest  out  REG_AW  register-file dest.
wr_mem_sel  out  1  register-file mem_data_in; 1 = entry came from memory.
wr_data  out  DATA_W  write data; integration ties it to both alu_data_in and memory_in.
q_src1, q_src2  in  REG_AW  lookup addresses, normally the operand stage's src1/src2.
q_hit1, q_hit2  out  1  a queued entry targets the address.
q_data1, q_data2  out  DATA_W  data of the youngest matching entry; 0 when no hit.
count  out  clog2(DEPTH)+1  occupancy.

Behaviour:
- Reset: all entries are invalidated and the pointers and count cleared. On reset, wr_en=0, wr_dest=0, wr_mem_sel=0, wr_data=0, count=0, and q_hit*=0. alu_ready and mem_ready are 0 while rst=1.
- Enqueue: at most one enqueue per cycle.
  - mem_ready = !full && !rst.
  - alu_ready = !full && !mem_valid && !rst. Memory has fixed priority; an ALU producer holds its result until accepted.
  - full is the registered condition count==DEPTH. A pop in the same cycle does not free a slot early.
- Each entry holds {dest, mem_sel, data}. Order is strict FIFO.
- Drain: wr_en, wr_dest, wr_mem_sel and wr_data are combinational from the head entry.
  - wr_en = !empty && !wr_hold.
  - The head is popped at the clock edge where wr_en=1, because the register file always accepts.
- Latency: without bypass, data accepted at edge N is written at edge N+1 at the earliest.
- Simultaneous push and pop: both take effect and count is unchanged. A push when full cannot occur.
- Pointers are log2(DEPTH) bits and wrap naturally. count increments on push-only and decrements on pop-only.
- Lookup is combinational over all valid entries.
  - q_hitN = OR of (valid && dest==q_srcN).
  - q_dataN selects the matching entry closest to the tail (youngest).
  - The head entry being written this cycle still reports a hit.
  - Entries being enqueued this cycle are not visible until the next cycle.
- Multiple queued writes to the same register drain in order, so the last write wins in the register file.
- Reset mid-operation discards all queued entries. Their writes are lost and producers must reissue.

Optional Feature:
WBQ_BYPASS_EN
- Defined: when the queue is empty and wr_hold=0, an accepted input goes straight to the wr_* outputs in the same cycle (zero latency) and is not enqueued. Memory still wins over ALU.
- Undefined: all writes pass through the queue, with a minimum latency of 1 cycle.
- Lookup behaviour is identical in both builds, since a bypassed write never becomes a queue entry.

Decomposition:
- Package wbq_pkg holds:
  - constants DATA_W=32 and REG_AW=4;
  - typedef wbq_entry_t {logic [REG_AW-1:0] dest; logic mem_sel; logic [DATA_W-1:0] data;}.
- Sub-module wbq_fifo: a parameterised circular buffer exposing push, pop, head entry, count, and the flat entry and valid vectors used for lookup.
- Arbitration, lookup and bypass live in writeback_queue.

Test Plan:
1. Single write: alu_valid with dest=3, result=0xDEADBEEF at edge 0 → at the next cycle wr_en=1, wr_dest=3, wr_mem_sel=0, wr_data=0xDEADBEEF; count goes 1→0. With WBQ_BYPASS_EN, wr_en=1 in the same cycle.
2. Arbitration: mem_valid (dest=5, 0x11) and alu_valid (dest=6, 0x22) in the same cycle → mem_ready=1, alu_ready=0. Drain order is r5/mem_sel=1 first, then r6/mem_sel=0.
3. Full: wr_hold=1 and 4 pushes → count=4, alu_ready=0, mem_ready=0. Release wr_hold → 4 consecutive writes in order, and ready reasserts the cycle after the first pop.
4. Forwarding: queue r2=0xA then r2=0xB with wr_hold=1, q_src1=2 → q_hit1=1, q_data1=0xB; q_src2=7 → q_hit2=0, q_data2=0.
5. Wrap-around: 10 pushes interleaved with pops at DEPTH=4 → every write appears in push order with correct data, and count never exceeds 4.
6. Reset mid-operation: queue 3 entries, assert rst for one cycle → wr_en=0, count=0, q_hit*=0; no stale write appears after rst deasserts.

Source files
------------

// File: rtl/wbq_pkg.sv
// Shared types and widths for the writeback queue.
// Included by the FIFO, the bus interface and the top.
package wbq_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 4;

  typedef struct packed {
    logic [REG_AW-1:0] dest;
    logic              mem_sel;
    logic [DATA_W-1:0] data;
  } wbq_entry_t;

endpackage

// File: rtl/writeback_queue_if.sv
// Producer, register-file and lookup bundle of the writeback queue.
// master = surrounding pipeline, slave = the queue itself.
interface writeback_queue_if
  import wbq_pkg::*;
#(
  parameter int DEPTH = 4
) ();

  localparam int CW = $clog2(DEPTH) + 1;

  logic              alu_valid;
  logic [REG_AW-1:0] alu_dest;
  logic [DATA_W-1:0] alu_result;
  logic              alu_ready;

  logic              mem_valid;
  logic [REG_AW-1:0] mem_dest;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;

  logic              wr_hold;
  logic              wr_en;
  logic [REG_AW-1:0] wr_dest;
  logic              wr_mem_sel;
  logic [DATA_W-1:0] wr_data;

  logic [REG_AW-1:0] q_src1;
  logic [REG_AW-1:0] q_src2;
  logic              q_hit1;
  logic              q_hit2;
  logic [DATA_W-1:0] q_data1;
  logic [DATA_W-1:0] q_data2;

  logic [CW-1:0]     count;

  modport master (
    output alu_valid, alu_dest, alu_result,
    output mem_valid, mem_dest, mem_data,
    output wr_hold, q_src1, q_src2,
    input  alu_ready, mem_ready,
    input  wr_en, wr_dest, wr_mem_sel, wr_data,
    input  q_hit1, q_hit2, q_data1, q_data2,
    input  count
  );

  modport slave (
    input  alu_valid, alu_dest, alu_result,
    input  mem_valid, mem_dest, mem_data,
    input  wr_hold, q_src1, q_src2,
    output alu_ready, mem_ready,
    output wr_en, wr_dest, wr_mem_sel, wr_data,
    output q_hit1, q_hit2, q_data1, q_data2,
    output count
  );

endinterface

// File: rtl/wbq_fifo.sv
// Circular buffer of writeback entries with per-slot valid bits
// exposed so the top can search every queued destination.
module wbq_fifo
  import wbq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = PW + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  wbq_entry_t             entry_i,
  input  logic                   pop_i,
  output wbq_entry_t             head_o,
  output logic [PW-1:0]          head_idx_o,
  output logic [CW-1:0]          count_o,
  output wbq_entry_t [DEPTH-1:0] entries_o,
  output logic [DEPTH-1:0]       valid_o
);

  wbq_entry_t [DEPTH-1:0] mem_q;
  logic [DEPTH-1:0]       vld_q, vld_d;
  logic [PW-1:0]          wp_q, wp_d;
  logic [PW-1:0]          rp_q, rp_d;
  logic [CW-1:0]          cnt_q, cnt_d;

  always_comb begin
    vld_d = vld_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    if (pop_i) begin
      vld_d[rp_q] = 1'b0;
      rp_d        = rp_q + PW'(1);
    end
    if (push_i) begin
      vld_d[wp_q] = 1'b1;
      wp_d        = wp_q + PW'(1);
    end
    unique case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // Payload needs no reset; the valid bits gate every use of it.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wp_q] <= entry_i;
  end

  assign head_o     = mem_q[rp_q];
  assign head_idx_o = rp_q;
  assign count_o    = cnt_q;
  assign entries_o  = mem_q;
  assign valid_o    = vld_q;

endmodule

// File: rtl/writeback_queue.sv
// In-order writeback queue feeding the register-file write port.
// Define WBQ_BYPASS_EN for zero-latency pass-through when empty.
module writeback_queue
  import wbq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  writeback_queue_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wbq_entry_t             head;
  wbq_entry_t [DEPTH-1:0] ents;
  logic [DEPTH-1:0]       vld;
  logic [PW-1:0]          head_idx;
  logic [CW-1:0]          cnt;

  logic       full, empty;
  logic       mem_acc, alu_acc, acc;
  logic       byp, push, pop;
  wbq_entry_t in_e, out_e;

  assign full  = cnt == CW'(DEPTH);
  assign empty = cnt == '0;

  // Loads win; an ALU result simply waits for a free cycle.
  assign bus.mem_ready = !full && !rst;
  assign bus.alu_ready = !full && !bus.mem_valid && !rst;

  assign mem_acc = bus.mem_valid && bus.mem_ready;
  assign alu_acc = bus.alu_valid && bus.alu_ready;
  assign acc     = mem_acc || alu_acc;

  always_comb begin
    in_e.dest    = bus.alu_dest;
    in_e.mem_sel = 1'b0;
    in_e.data    = bus.alu_result;
    if (mem_acc) begin
      in_e.dest    = bus.mem_dest;
      in_e.mem_sel = 1'b1;
      in_e.data    = bus.mem_data;
    end
  end

`ifdef WBQ_BYPASS_EN
  assign byp = acc && empty && !bus.wr_hold;
`else
  assign byp = 1'b0;
`endif

  assign push = acc && !byp;
  assign pop  = !empty && !bus.wr_hold && !rst;

  wbq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .entry_i    (in_e),
    .pop_i      (pop),
    .head_o     (head),
    .head_idx_o (head_idx),
    .count_o    (cnt),
    .entries_o  (ents),
    .valid_o    (vld)
  );

  always_comb begin
    out_e = '0;
    unique case (1'b1)
      !empty && !rst: out_e = head;
      byp:            out_e = in_e;
      default:        out_e = '0;
    endcase
  end

  assign bus.wr_en      = pop || byp;
  assign bus.wr_dest    = out_e.dest;
  assign bus.wr_mem_sel = out_e.mem_sel;
  assign bus.wr_data    = out_e.data;
  assign bus.count      = cnt;

  // Walk oldest to youngest so the last match left standing wins.
  function automatic logic [DATA_W:0] lookup(
    input logic [REG_AW-1:0]    src,
    input wbq_entry_t [DEPTH-1:0] e,
    input logic [DEPTH-1:0]     v,
    input logic [PW-1:0]        h
  );
    logic [PW-1:0] idx;
    lookup = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = h + PW'(k);
      if (v[idx] && e[idx].dest == src) begin
        lookup = {1'b1, e[idx].data};
      end
    end
  endfunction

  logic [DATA_W:0] lk1, lk2;

  always_comb begin
    lk1 = '0;
    lk2 = '0;
    if (!rst) begin
      lk1 = lookup(bus.q_src1, ents, vld, head_idx);
      lk2 = lookup(bus.q_src2, ents, vld, head_idx);
    end
  end

  assign {bus.q_hit1, bus.q_data1} = lk1;
  assign {bus.q_hit2, bus.q_data2} = lk2;

endmodule

// File: tb/tb_writeback_queue.sv
// Randomized and directed bench for writeback_queue against a queue model.
// Honours WBQ_BYPASS_EN the same way as the design.
module tb_writeback_queue;

  localparam int DEPTH = 4;

`ifdef WBQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  writeback_queue_if #(.DEPTH(DEPTH)) bus ();

  writeback_queue #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0]  d;
    logic        m;
    logic [31:0] v;
  } ent_t;

  ent_t q[$];
  int   errs = 0;
  int   chks = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    chks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Youngest queued write to s, as {hit, data}.
  function automatic logic [32:0] ref_look(input logic [3:0] s);
    logic [32:0] r;
    r = '0;
    foreach (q[i]) if (q[i].d == s) r = {1'b1, q[i].v};
    return r;
  endfunction

  task automatic step(input logic r,
                      input logic av, input logic [3:0] ad,
                      input logic [31:0] ar,
                      input logic mv, input logic [3:0] md,
                      input logic [31:0] mdat,
                      input logic hold,
                      input logic [3:0] s1, input logic [3:0] s2);
    ent_t        in_e, out_e;
    bit          full, empty, mrdy, ardy, macc, acc, byp, wen;
    logic [32:0] l1, l2;
    @(negedge clk);
    rst            = r;
    bus.alu_valid  = av;
    bus.alu_dest   = ad;
    bus.alu_result = ar;
    bus.mem_valid  = mv;
    bus.mem_dest   = md;
    bus.mem_data   = mdat;
    bus.wr_hold    = hold;
    bus.q_src1     = s1;
    bus.q_src2     = s2;
    #2;
    full  = q.size() == DEPTH;
    empty = q.size() == 0;
    mrdy  = !full && !r;
    ardy  = !full && !mv && !r;
    macc  = mv && mrdy;
    acc   = macc || (av && ardy);
    if (macc) in_e = '{md, 1'b1, mdat};
    else      in_e = '{ad, 1'b0, ar};
    byp = BYP && acc && empty && !hold;
    wen = (!empty && !hold && !r) || byp;
    out_e = '{4'h0, 1'b0, 32'h0};
    if (!empty && !r) out_e = q[0];
    else if (byp)     out_e = in_e;
    l1 = r ? 33'h0 : ref_look(s1);
    l2 = r ? 33'h0 : ref_look(s2);
    check("mem_ready", bus.mem_ready, mrdy);
    check("alu_ready", bus.alu_ready, ardy);
    check("wr_en", bus.wr_en, wen);
    check("wr_dest", bus.wr_dest, out_e.d);
    check("wr_mem_sel", bus.wr_mem_sel, out_e.m);
    check("wr_data", bus.wr_data, out_e.v);
    check("q_hit1", bus.q_hit1, l1[32]);
    check("q_data1", bus.q_data1, l1[31:0]);
    check("q_hit2", bus.q_hit2, l2[32]);
    check("q_data2", bus.q_data2, l2[31:0]);
    check("count", bus.count, q.size());
    check("count_max", bus.count <= DEPTH, 1);
    @(posedge clk);
    if (r) begin
      q.delete();
    end else begin
      if (!empty && !hold) void'(q.pop_front());
      if (acc && !byp) q.push_back(in_e);
    end
  endtask

  task automatic idle(input logic hold, input int n);
    repeat (n) step(1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0,
                    hold, 4'($urandom), 4'($urandom));
  endtask

  task automatic alu(input logic [3:0] d, input logic [31:0] v,
                     input logic hold, input logic [3:0] s1);
    step(1'b0, 1'b1, d, v, 1'b0, 4'h0, 32'h0, hold, s1, 4'h7);
  endtask

  initial begin
    bus.alu_valid  = 1'b0;
    bus.alu_dest   = '0;
    bus.alu_result = '0;
    bus.mem_valid  = 1'b0;
    bus.mem_dest   = '0;
    bus.mem_data   = '0;
    bus.wr_hold    = 1'b0;
    bus.q_src1     = '0;
    bus.q_src2     = '0;
    repeat (2) @(posedge clk);
    // Reset state
    step(1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 4'h0);
    // Single write
    alu(4'd3, 32'hDEADBEEF, 1'b0, 4'd3);
    idle(1'b0, 2);
    // Arbitration, ALU holds its offer
    step(1'b0, 1'b1, 4'd6, 32'h22, 1'b1, 4'd5, 32'h11, 1'b0, 4'd5, 4'd6);
    step(1'b0, 1'b1, 4'd6, 32'h22, 1'b0, 4'd0, 32'h0, 1'b0, 4'd5, 4'd6);
    idle(1'b0, 3);
    // Fill under hold, then release
    for (int i = 0; i < 4; i++) alu(4'(i + 8), 32'h100 + i, 1'b1, 4'd9);
    alu(4'd1, 32'h55, 1'b1, 4'd8);
    idle(1'b0, 5);
    // Forwarding of the youngest duplicate
    alu(4'd2, 32'hA, 1'b1, 4'd2);
    alu(4'd2, 32'hB, 1'b1, 4'd2);
    step(1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 4'd2, 4'd7);
    idle(1'b0, 3);
    // Wrap-around with interleaved pops
    for (int i = 0; i < 10; i++)
      alu(4'(i), 32'h111 * (i + 1), 1'(i % 3 == 0), 4'(i));
    idle(1'b0, 6);
    // Reset mid-operation
    for (int i = 0; i < 3; i++) alu(4'(i + 1), 32'hC0 + i, 1'b1, 4'd1);
    step(1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 4'd1, 4'd2);
    idle(1'b0, 3);
    // Random traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 49) == 0),
           1'($urandom), 4'($urandom), $urandom,
           1'($urandom_range(0, 2) == 0), 4'($urandom), $urandom,
           1'($urandom_range(0, 3) == 0),
           4'($urandom), 4'($urandom));
    idle(1'b0, 6);
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule
